// File: rtl/tiny_alu_pkg.sv
// rtl/tiny_alu_pkg.sv - shared types, widths and decode helpers for the tiny ALU
//
// Purpose: opcode enumeration, fixed data-path widths and small pure functions
//          used by the top-level decode and the single-cycle unit.
// Ports:   none (package)
package tiny_alu_pkg;

  localparam int OPERAND_W = 8;
  localparam int RESULT_W  = 16;
  localparam int OP_W      = 3;

  // 3'b101 and 3'b110 are deliberately left out; they decode as no operation.
  typedef enum logic [OP_W-1:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } operation_t;

  function automatic logic is_single_cycle(input logic [OP_W-1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      add_op, and_op, xor_op: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_mul(input logic [OP_W-1:0] op);
    return (op == mul_op);
  endfunction

  // Add keeps its carry in bit 8; logic ops are zero-extended.
  function automatic logic [RESULT_W-1:0] single_cycle_result(
    input logic [OP_W-1:0]      op,
    input logic [OPERAND_W-1:0] a,
    input logic [OPERAND_W-1:0] b
  );
    logic [RESULT_W-1:0] r;
    r = '0;
    case (op)
      add_op:  r = {7'b0, ({1'b0, a} + {1'b0, b})};
      and_op:  r = {8'b0, (a & b)};
      xor_op:  r = {8'b0, (a ^ b)};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tiny_alu_if.sv
// rtl/tiny_alu_if.sv - requester/ALU handshake bundle for the tiny ALU
//
// Purpose: groups operands, opcode, start/done handshake and result.
// Signals: A, B   operands, unsigned
//          op     opcode (see tiny_alu_pkg::operation_t)
//          start  request, held by the requester until done is seen
//          done   one-cycle completion pulse
//          result operation result, valid when done=1, held afterwards
// Modports: master = requester/BFM, slave = ALU
interface tiny_alu_if;
  import tiny_alu_pkg::*;

  logic [OPERAND_W-1:0] A;
  logic [OPERAND_W-1:0] B;
  logic [OP_W-1:0]      op;
  logic                 start;
  logic                 done;
  logic [RESULT_W-1:0]  result;

  modport master (
    output A, B, op, start,
    input  done, result
  );

  modport slave (
    input  A, B, op, start,
    output done, result
  );

endinterface

// File: rtl/tiny_alu_mult.sv
// rtl/tiny_alu_mult.sv - 3-stage pipelined 8x8 unsigned multiplier
//
// Purpose: stage 1 captures operands, stage 2 forms two 8x4 partial products,
//          stage 3 sums them. A valid bit travels alongside the data.
// Ports:   clk          rising-edge clock
//          reset_n      asynchronous active-low reset, clears the valid pipeline
//          in_valid     load operands this edge
//          in_a, in_b   operands
//          busy         an operation sits in stage 1 or 2
//          out_valid    product available this cycle (one cycle)
//          out_product  16-bit product, held until the next product
module tiny_alu_mult
  import tiny_alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [OPERAND_W-1:0] in_a,
  input  logic [OPERAND_W-1:0] in_b,
  output logic                 busy,
  output logic                 out_valid,
  output logic [RESULT_W-1:0]  out_product
);

  logic                 s1_valid;
  logic [OPERAND_W-1:0] s1_a;
  logic [OPERAND_W-1:0] s1_b;

  logic                 s2_valid;
  logic [11:0]          s2_lo;
  logic [11:0]          s2_hi;

  logic                 s3_valid;
  logic [RESULT_W-1:0]  s3_prod;

  // Stage 1: operand capture, so the requester may change A/B after accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a <= in_a;
        s1_b <= in_b;
      end
    end
  end

  // Stage 2: split B into nibbles to keep each multiplier narrow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_lo    <= '0;
      s2_hi    <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_lo <= {4'b0, s1_a} * {8'b0, s1_b[3:0]};
        s2_hi <= {4'b0, s1_a} * {8'b0, s1_b[7:4]};
      end
    end
  end

  // Stage 3: recombine the partial products.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s3_valid <= 1'b0;
      s3_prod  <= '0;
    end else begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_prod <= {4'b0, s2_lo} + {s2_hi, 4'b0};
      end
    end
  end

  assign busy        = s1_valid | s2_valid;
  assign out_valid   = s3_valid;
  assign out_product = s3_prod;

endmodule

// File: rtl/tiny_alu.sv
// rtl/tiny_alu.sv - 8-bit ALU with start/done handshake
//
// Purpose: decodes the request, runs add/and/xor in one cycle or mul through
//          the 3-stage multiplier, and presents a single done pulse plus a
//          result that holds its last completed value.
// Ports:   clk      rising-edge clock
//          reset_n  asynchronous active-low reset; aborts any op in flight
//          bus      tiny_alu_if slave: A, B, op, start in; done, result out
module tiny_alu
  import tiny_alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  tiny_alu_if.slave  bus
);

  logic                accept;
  logic                mul_busy;
  logic                mul_valid;
  logic [RESULT_W-1:0] mul_product;

  logic                sc_done;
  logic [RESULT_W-1:0] sc_result;

  logic                done_int;
  logic [RESULT_W-1:0] result_int;
  logic [RESULT_W-1:0] last_result;

  // A request is taken only when idle. The done cycle also blocks acceptance
  // because the requester still holds start high across that edge. Non-ALU
  // opcodes are "accepted" here but launch nothing.
  assign accept = bus.start && !mul_busy && !done_int;

  tiny_alu_mult u_mult (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (accept && is_mul(bus.op)),
    .in_a        (bus.A),
    .in_b        (bus.B),
    .busy        (mul_busy),
    .out_valid   (mul_valid),
    .out_product (mul_product)
  );

  // Single-cycle unit: result registered at the accept edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sc_done   <= 1'b0;
      sc_result <= '0;
    end else begin
      sc_done <= accept && is_single_cycle(bus.op);
      if (accept && is_single_cycle(bus.op)) begin
        sc_result <= single_cycle_result(bus.op, bus.A, bus.B);
      end
    end
  end

  // Completions from the two units never coincide: accept is blocked while
  // the multiplier is busy, so a simple priority mux suffices.
  always_comb begin
    done_int   = 1'b0;
    result_int = last_result;
    if (mul_valid) begin
      done_int   = 1'b1;
      result_int = mul_product;
    end else if (sc_done) begin
      done_int   = 1'b1;
      result_int = sc_result;
    end
  end

  // Tracks the visible result so it persists after the done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_result <= '0;
    end else begin
      last_result <= result_int;
    end
  end

  assign bus.done   = done_int;
  assign bus.result = result_int;

endmodule

// File: tb/tb_tiny_alu.sv
// tb/tb_tiny_alu.sv - self-checking bench for tiny_alu
module tb_tiny_alu;
  import tiny_alu_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  tiny_alu_if bus ();

  tiny_alu dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit is_alu_op(input logic [2:0] op);
    return (op == add_op) || (op == and_op) || (op == xor_op) || (op == mul_op);
  endfunction

  // BFM: raise start, wait (bounded) for done, drop start, then watch for
  // stray done pulses. hold_extra keeps start high one cycle past done.
  task automatic run_op(input logic [2:0] op_i, input logic [7:0] a_i, input logic [7:0] b_i,
                        input bit hold_extra, output int lat, output logic [15:0] res,
                        output int extra);
    @(negedge clk);
    bus.A = a_i; bus.B = b_i; bus.op = op_i; bus.start = 1'b1;
    lat = 0; res = '0; extra = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.A = ~a_i;
        bus.B = ~b_i;
      end
      if (bus.done) begin
        lat = c;
        res = bus.result;
      end else if (c == 1 && !is_alu_op(op_i)) begin
        bus.start = 1'b0;
      end
    end
    if (lat != 0 && hold_extra) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    bus.start = 1'b0;
    if (lat == 0) res = bus.result;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int extra;
    int dcnt;
    logic [15:0] res;
    logic [15:0] exp_r;
    logic [2:0]  rop;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [2:0]  op_tab [4];

    op_tab[0] = add_op; op_tab[1] = and_op; op_tab[2] = xor_op; op_tab[3] = mul_op;

    vecs.push_back('{add_op, 8'hFF, 8'hFF, 16'h01FE, 1});
    vecs.push_back('{and_op, 8'hF0, 8'h3C, 16'h0030, 1});
    vecs.push_back('{xor_op, 8'hAA, 8'h55, 16'h00FF, 1});
    vecs.push_back('{mul_op, 8'hFF, 8'hFF, 16'hFE01, 3});
    vecs.push_back('{no_op,  8'h12, 8'h34, 16'hFE01, 0});
    vecs.push_back('{add_op, 8'h80, 8'h7F, 16'h00FF, 1});
    vecs.push_back('{rst_op, 8'h01, 8'h01, 16'h00FF, 0});
    vecs.push_back('{mul_op, 8'h00, 8'hAB, 16'h0000, 3});
    vecs.push_back('{3'b101, 8'h11, 8'h22, 16'h0000, 0});
    vecs.push_back('{mul_op, 8'h10, 8'h10, 16'h0100, 3});
    vecs.push_back('{3'b110, 8'h33, 8'h44, 16'h0100, 0});
    vecs.push_back('{xor_op, 8'hFF, 8'h0F, 16'h00F0, 1});
    vecs.push_back('{mul_op, 8'h0F, 8'hF0, 16'h0E10, 3});
    vecs.push_back('{add_op, 8'h01, 8'hFF, 16'h0100, 1});

    bus.A = '0; bus.B = '0; bus.op = '0; bus.start = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", 32'(bus.result), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d_done", i), 32'(bus.done), 32'd0);
      check($sformatf("idle%0d_result", i), 32'(bus.result), 32'd0);
    end

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat, res, extra);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp_res));
      check($sformatf("vec%0d_extra_done", i), 32'(extra), 32'd0);
    end

    // start held across the done cycle must not relaunch the op
    run_op(mul_op, 8'd2, 8'd3, 1'b1, lat, res, extra);
    check("hold_mul_latency", 32'(lat), 32'd3);
    check("hold_mul_result", 32'(res), 32'h0006);
    check("hold_mul_extra_done", 32'(extra), 32'd0);
    run_op(add_op, 8'd5, 8'd6, 1'b1, lat, res, extra);
    check("hold_add_latency", 32'(lat), 32'd1);
    check("hold_add_result", 32'(res), 32'h000B);
    check("hold_add_extra_done", 32'(extra), 32'd0);

    // opcode changes before the accept edge: the sampled value wins
    @(negedge clk);
    bus.A = 8'd3; bus.B = 8'd4; bus.op = add_op; bus.start = 1'b1;
    #2 bus.op = mul_op;
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = c;
        res = bus.result;
      end
    end
    bus.start = 1'b0;
    check("late_op_latency", 32'(lat), 32'd3);
    check("late_op_result", 32'(res), 32'h000C);
    repeat (3) @(negedge clk);

    // reset mid-multiply aborts it and clears result immediately
    @(negedge clk);
    bus.A = 8'd10; bus.B = 8'd10; bus.op = mul_op; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_reset_result", 32'(bus.result), 32'd0);
    check("async_reset_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    dcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    check("abort_no_done", 32'(dcnt), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);

    // random ALU ops against a behavioural model
    exp_r = '0;
    for (int i = 0; i < 20; i++) begin
      rop = op_tab[$urandom_range(0, 3)];
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      case (rop)
        add_op:  exp_r = 16'(ra) + 16'(rb);
        and_op:  exp_r = 16'(ra & rb);
        xor_op:  exp_r = 16'(ra ^ rb);
        default: exp_r = 16'(ra) * 16'(rb);
      endcase
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)), lat, res, extra);
      check($sformatf("rand%0d_latency", i), 32'(lat), (rop == mul_op) ? 32'd3 : 32'd1);
      check($sformatf("rand%0d_result", i), 32'(res), 32'(exp_r));
      check($sformatf("rand%0d_extra_done", i), 32'(extra), 32'd0);
    end

    run_op(no_op, 8'h5A, 8'hA5, 1'b0, lat, res, extra);
    check("final_noop_latency", 32'(lat), 32'd0);
    check("final_noop_result", 32'(res), 32'(exp_r));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
